sram_port_arbiter: RTL and testbench

- Shares one SRAM-like master port (toward axi_bridge) between the IF-stage instruction requester and the EXE-stage data requester.
- Arbitrates request phases and holds the grant until addr_ok.
- Records the owner of every accepted request in an in-order owner FIFO, and routes each data_ok/rdata back to the correct requester.
- Downstream responses are in order of acceptance.

---
 rtl/sram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like master port between the instruction and data requesters.
// Responses are routed through an in-order owner FIFO. Define ARB_RR_EN for round-robin grants.
module sram_port_arbiter #(
   parameter int unsigned MAX_OUT = 4,
   parameter int unsigned CNT_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [3:0]        inst_wstrb,
   input  logic [31:0]       inst_addr,
   input  logic [31:0]       inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [3:0]        data_wstrb,
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,
   output logic              sram_req,
   output logic              sram_wr,
   output logic [1:0]        sram_size,
   output logic [3:0]        sram_wstrb,
   output logic [31:0]       sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic              sram_addr_ok,
   input  logic              sram_data_ok,
   input  logic [31:0]       sram_rdata,
   output logic [CNT_W-1:0]  outstanding,
   output logic              err_unexp_rsp
);

   localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUT);

   typedef enum logic [1:0] {StIdle, StLockI, StLockD} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [MAX_OUT-1:0] owner_q;
   logic               err_q;

   logic full, empty, pick_data, gnt_vld, gnt_data, accept, pop, pop_owner;

`ifdef ARB_RR_EN
   logic rr_q;
   assign pick_data = (inst_req & data_req) ? rr_q : data_req;
`else
   assign pick_data = data_req;
`endif

   assign full  = (cnt_q == MaxCnt);
   assign empty = (cnt_q == '0);

   // A held lock keeps presenting its owner even when the FIFO is full.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_data = 1'b0;
      case (state_q)
         StLockI: gnt_vld = 1'b1;
         StLockD: begin
            gnt_vld  = 1'b1;
            gnt_data = 1'b1;
         end
         default: begin
            gnt_vld  = ~full & (inst_req | data_req);
            gnt_data = pick_data;
         end
      endcase
   end

   assign sram_req   = gnt_vld & ~reset;
   assign sram_wr    = gnt_data ? data_wr    : inst_wr;
   assign sram_size  = gnt_data ? data_size  : inst_size;
   assign sram_wstrb = gnt_data ? data_wstrb : inst_wstrb;
   assign sram_addr  = gnt_data ? data_addr  : inst_addr;
   assign sram_wdata = gnt_data ? data_wdata : inst_wdata;

   assign accept       = sram_req & sram_addr_ok;
   assign inst_addr_ok = accept & ~gnt_data;
   assign data_addr_ok = accept & gnt_data;

   assign pop          = sram_data_ok & ~empty & ~reset;
   assign pop_owner    = owner_q[rptr_q];
   assign inst_data_ok = pop & ~pop_owner;
   assign data_data_ok = pop & pop_owner;
   assign inst_rdata   = sram_rdata;
   assign data_rdata   = sram_rdata;

   assign outstanding   = cnt_q;
   assign err_unexp_rsp = err_q;

   assign cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         owner_q <= '0;
         err_q   <= 1'b0;
`ifdef ARB_RR_EN
         rr_q    <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            StIdle: begin
               if (sram_req & ~sram_addr_ok) state_q <= gnt_data ? StLockD : StLockI;
            end
            default: begin
               if (sram_addr_ok) state_q <= StIdle;
            end
         endcase
         if (accept) begin
            owner_q[wptr_q] <= gnt_data;
            wptr_q          <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         if (sram_data_ok & empty) err_q <= 1'b1;
`ifdef ARB_RR_EN
         if (accept) rr_q <= ~gnt_data;
`endif
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, hand sequences, and random traffic
// checked against a queue-based reference model.
module tb_sram_port_arbiter;

   localparam int MAX_OUT = 4;
   localparam logic [31:0] IA = 32'h1C00_0000;
   localparam logic [31:0] DA = 32'h0000_1000;
   localparam logic [31:0] RD = 32'h0280_0000;

   logic clk = 1'b0;
   logic reset;
   logic inst_req, inst_wr, data_req, data_wr;
   logic [1:0] inst_size, data_size, sram_size;
   logic [3:0] inst_wstrb, data_wstrb, sram_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic sram_req, sram_wr, sram_addr_ok, sram_data_ok;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;
   logic [2:0] outstanding;
   logic err_unexp_rsp;

   always #5 clk = ~clk;

   sram_port_arbiter #(.MAX_OUT(MAX_OUT), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
      .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
      .outstanding(outstanding), .err_unexp_rsp(err_unexp_rsp)
   );

   typedef struct {
      bit rst, ireq, dreq, aok, dok;
      bit e_req;
      logic [31:0] e_addr;
      bit e_iaok, e_daok, e_idok, e_ddok;
      int e_out;
      bit e_err;
   } vec_t;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: owner queue, held-grant owner (-1 none), rr pointer, sticky error.
   int q_own[$];
   int held = -1;
   bit rr = 1'b0;
   bit err_m = 1'b0;
   bit m_req, m_acc, m_pop;
   int m_own, m_pop_own;

   vec_t tab[$];

   function automatic vec_t mk(bit rst, bit ireq, bit dreq, bit aok, bit dok, bit ereq,
                               logic [31:0] eaddr, bit eia, bit eda, bit eid, bit edd,
                               int eout, bit eerr);
      vec_t v;
      v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok;
      v.e_req = ereq; v.e_addr = eaddr; v.e_iaok = eia; v.e_daok = eda;
      v.e_idok = eid; v.e_ddok = edd; v.e_out = eout; v.e_err = eerr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      reset = v.rst;
      inst_req = v.ireq; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
      inst_addr = IA; inst_wdata = 32'hAAAA_0001;
      data_req = v.dreq; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3;
      data_addr = DA; data_wdata = 32'h5555_0002;
      sram_addr_ok = v.aok; sram_data_ok = v.dok; sram_rdata = RD;
   endtask

   task automatic model_eval();
      m_req = 1'b0;
      m_own = 0;
      if (!reset) begin
         if (held >= 0) begin
            m_req = 1'b1;
            m_own = held;
         end else if (q_own.size() < MAX_OUT && (inst_req || data_req)) begin
            m_req = 1'b1;
`ifdef ARB_RR_EN
            m_own = (inst_req && data_req) ? int'(rr) : (data_req ? 1 : 0);
`else
            m_own = data_req ? 1 : 0;
`endif
         end
      end
      m_acc = m_req && sram_addr_ok;
      m_pop = !reset && sram_data_ok && q_own.size() > 0;
      m_pop_own = m_pop ? q_own[0] : 0;
   endtask

   task automatic model_check();
      check("sram_req", {31'd0, sram_req}, {31'd0, m_req});
      if (m_req) begin
         check("sram_addr", sram_addr, m_own == 1 ? data_addr : inst_addr);
         check("sram_wdata", sram_wdata, m_own == 1 ? data_wdata : inst_wdata);
         check("sram_ctl", {25'd0, sram_wr, sram_size, sram_wstrb},
               m_own == 1 ? {25'd0, data_wr, data_size, data_wstrb}
                          : {25'd0, inst_wr, inst_size, inst_wstrb});
      end
      check("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, m_acc && m_own == 0});
      check("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, m_acc && m_own == 1});
      check("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, m_pop && m_pop_own == 0});
      check("data_data_ok", {31'd0, data_data_ok}, {31'd0, m_pop && m_pop_own == 1});
      if (m_pop) begin
         check("inst_rdata", inst_rdata, sram_rdata);
         check("data_rdata", data_rdata, sram_rdata);
      end
      check("outstanding", {29'd0, outstanding}, q_own.size());
      check("err_unexp_rsp", {31'd0, err_unexp_rsp}, {31'd0, err_m});
   endtask

   task automatic model_update();
      if (reset) begin
         q_own.delete();
         held = -1;
         rr = 1'b0;
         err_m = 1'b0;
      end else begin
         if (sram_data_ok && q_own.size() == 0) err_m = 1'b1;
         if (m_pop) void'(q_own.pop_front());
         if (m_acc) q_own.push_back(m_own);
         held = (m_req && !sram_addr_ok) ? m_own : -1;
         if (m_acc) rr = (m_own == 0);
      end
   endtask

   task automatic cycle(input bit has_tab, input vec_t v);
      @(negedge clk);
      model_eval();
      model_check();
      if (has_tab) begin
         check("tab_sram_req", {31'd0, sram_req}, {31'd0, v.e_req});
         if (v.e_req) check("tab_sram_addr", sram_addr, v.e_addr);
         check("tab_inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, v.e_iaok});
         check("tab_data_addr_ok", {31'd0, data_addr_ok}, {31'd0, v.e_daok});
         check("tab_inst_data_ok", {31'd0, inst_data_ok}, {31'd0, v.e_idok});
         check("tab_data_data_ok", {31'd0, data_data_ok}, {31'd0, v.e_ddok});
         if (v.e_idok) check("tab_inst_rdata", inst_rdata, RD);
         if (v.e_ddok) check("tab_data_rdata", data_rdata, RD);
         check("tab_outstanding", {29'd0, outstanding}, v.e_out);
         check("tab_err", {31'd0, err_unexp_rsp}, {31'd0, v.e_err});
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic run(input vec_t v);
      apply(v);
      cycle(1'b1, v);
   endtask

   initial begin
      vec_t z;
      z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(z);
      repeat (2) @(posedge clk);
      #1;
      // Reset held with every input active: handshakes must stay low.
      run(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

`ifndef ARB_RR_EN
      // rst ireq dreq aok dok | req addr iaok daok idok ddok out err
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 0, 1, 0, 1, IA, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 1, 1, 0, 1, DA, 0, 1, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 0, 1, 0, 1, IA, 1, 0, 0, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 2, 0));
      tab.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 1, 0, 0, 1, DA, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 1, 0, 0, 1, DA, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 1, 0, 0, 1, DA, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 1, 1, 0, 1, DA, 0, 1, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 0, 1, 0, 1, IA, 1, 0, 0, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 2, 0));
      tab.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      for (int i = 0; i < tab.size(); i++) run(tab[i]);
`else
      // Round-robin alternation from reset, then drain.
      run(mk(0, 1, 1, 1, 0, 1, IA, 1, 0, 0, 0, 0, 0));
      run(mk(0, 1, 1, 1, 0, 1, DA, 0, 1, 0, 0, 1, 0));
      run(mk(0, 1, 1, 1, 0, 1, IA, 1, 0, 0, 0, 2, 0));
      run(mk(0, 1, 1, 1, 0, 1, DA, 0, 1, 0, 0, 3, 0));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 4, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 3, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 2, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 0));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
`endif

      // Fill to MAX_OUT in order I,D,I,D, blocked 5th request, then in-order routing.
      run(mk(0, 1, 0, 1, 0, 1, IA, 1, 0, 0, 0, 0, 0));
      run(mk(0, 0, 1, 1, 0, 1, DA, 0, 1, 0, 0, 1, 0));
      run(mk(0, 1, 0, 1, 0, 1, IA, 1, 0, 0, 0, 2, 0));
      run(mk(0, 0, 1, 1, 0, 1, DA, 0, 1, 0, 0, 3, 0));
      run(mk(0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4, 0));
      run(mk(0, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 4, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 4, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 3, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 2, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 0));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

      // Push and pop together at outstanding=2, then unexpected responses.
      run(mk(0, 1, 0, 1, 0, 1, IA, 1, 0, 0, 0, 0, 0));
      run(mk(0, 0, 1, 1, 0, 1, DA, 0, 1, 0, 0, 1, 0));
      run(mk(0, 1, 0, 1, 1, 1, IA, 1, 0, 1, 0, 2, 0));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 2, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 1, 0));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
      run(mk(0, 1, 0, 1, 1, 1, IA, 1, 0, 0, 0, 0, 1));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 1, 1));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));

      // Reset while a data lock is held with one request in flight.
      run(mk(0, 1, 0, 1, 0, 1, IA, 1, 0, 0, 0, 0, 1));
      run(mk(0, 0, 1, 0, 0, 1, DA, 0, 0, 0, 0, 1, 1));
      run(mk(1, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1, 1));
      run(mk(0, 1, 0, 1, 0, 1, IA, 1, 0, 0, 0, 0, 0));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
      run(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 1, 0));
      run(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

      // Random traffic; requesters hold their fields until accepted.
      inst_req = 1'b0;
      data_req = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(299) == 0);
         if (!inst_req) begin
            inst_req = $urandom_range(1);
            inst_wr = $urandom_range(1);
            inst_size = 2'($urandom_range(3));
            inst_wstrb = 4'($urandom_range(15));
            inst_addr = $urandom;
            inst_wdata = $urandom;
         end
         if (!data_req) begin
            data_req = $urandom_range(1);
            data_wr = $urandom_range(1);
            data_size = 2'($urandom_range(3));
            data_wstrb = 4'($urandom_range(15));
            data_addr = $urandom;
            data_wdata = $urandom;
         end
         sram_addr_ok = ($urandom_range(2) != 0);
         sram_data_ok = (q_own.size() > 0) ? 1'($urandom_range(1))
                                          : ($urandom_range(49) == 0);
         sram_rdata = $urandom;
         cycle(1'b0, z);
         if (reset) begin
            inst_req = 1'b0;
            data_req = 1'b0;
         end else begin
            if (m_acc && m_own == 0) inst_req = 1'b0;
            if (m_acc && m_own == 1) data_req = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
